// File: rtl/immu_pkg.sv
// Shared definitions for the instruction/data MMU walkers: TLB entry layout,
// exception codes, walker state encoding and the page-size mask helper.
package immu_pkg;

  localparam int SIZE_MAX = 7;

  localparam int E_V      = 63;
  localparam int E_TS     = 62;
  localparam int E_TID_HI = 61;
  localparam int E_TID_LO = 54;
  localparam int E_EPN_HI = 53;
  localparam int E_EPN_LO = 34;
  localparam int E_SIZ_HI = 33;
  localparam int E_SIZ_LO = 30;
  localparam int E_RPN_HI = 29;
  localparam int E_RPN_LO = 10;
  localparam int E_UX     = 9;
  localparam int E_SX     = 6;

  localparam logic [4:0] EXC_NONE      = 5'd0;
  localparam logic [4:0] EXC_ITLB_MISS = 5'd1;
  localparam logic [4:0] EXC_ISI       = 5'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } walk_state_t;

  // Page number mask: clears 2*SIZE low bits; SIZE above SIZE_MAX saturates.
  function automatic logic [19:0] page_mask(input logic [3:0] size);
    logic [2:0] s;
    s = size[3] ? 3'(SIZE_MAX) : size[2:0];
    return 20'hFFFFF << {s, 1'b0};
  endfunction

endpackage

// File: rtl/immu_entry_match.sv
// Combinational compare of one TLB entry against a translation context:
// valid/TS/TID/EPN match, page mask and execute permission.
module immu_entry_match
  import immu_pkg::*;
(
  input  logic [63:0] i_entry,
  input  logic [19:0] i_ea_pn,
  input  logic [7:0]  i_pid0,
  input  logic [7:0]  i_pid1,
  input  logic [7:0]  i_pid2,
  input  logic        i_is,
  input  logic        i_pr,
  output logic        o_match,
  output logic [19:0] o_mask,
  output logic        o_exec_ok
);

  logic [7:0]  w_tid;
  logic [19:0] w_epn;
  logic        w_tid_ok;
  logic        w_unused_bits;

  assign w_tid    = i_entry[E_TID_HI:E_TID_LO];
  assign w_epn    = i_entry[E_EPN_HI:E_EPN_LO];
  assign o_mask   = page_mask(i_entry[E_SIZ_HI:E_SIZ_LO]);
  // TID 0 is a global mapping that matches every process.
  assign w_tid_ok = (w_tid == 8'd0) || (w_tid == i_pid0) ||
                    (w_tid == i_pid1) || (w_tid == i_pid2);

  assign o_match  = i_entry[E_V] && (i_entry[E_TS] == i_is) && w_tid_ok &&
                    ((i_ea_pn & o_mask) == (w_epn & o_mask));
  assign o_exec_ok = i_pr ? i_entry[E_UX] : i_entry[E_SX];

  // RPN and the read/write permissions are consumed elsewhere, not here.
  assign w_unused_bits = ^{i_entry[E_RPN_HI:E_RPN_LO], i_entry[8:7], i_entry[5:0]};

endmodule

// File: rtl/immu_tlb_walker.sv
// Instruction-fetch TLB walker: scans the TLB one entry per cycle through a
// 1-cycle read port and returns PA / Miss / Exception for one fetch EA.
module immu_tlb_walker
  import immu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_ea,
  input  logic [7:0]       pid0,
  input  logic [7:0]       pid1,
  input  logic [7:0]       pid2,
  input  logic             msr_is,
  input  logic             msr_pr,
  input  logic             flush,
  output logic             tlb_rd_en,
  output logic [IDX_W-1:0] tlb_rd_idx,
  input  logic [63:0]      tlb_rd_data,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_pa,
  output logic [IDX_W-1:0] resp_idx,
  output logic             Miss,
  output logic [4:0]       Exception
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  walk_state_t      r_state, w_next_state;
  logic             r_req_ready;
  logic [31:0]      r_ea;
  logic [7:0]       r_pid0, r_pid1, r_pid2;
  logic             r_is, r_pr;
  logic             r_rd_en;
  logic [IDX_W-1:0] r_rd_idx;
  logic             r_data_vld;
  logic [IDX_W-1:0] r_data_idx;
  logic [31:0]      r_resp_pa;
  logic [IDX_W-1:0] r_resp_idx;
  logic             r_miss;
  logic [4:0]       r_exc;

  logic             w_accept, w_hit, w_scan_end, w_match, w_exec_ok;
  logic [19:0]      w_mask, w_rpn;

  immu_entry_match u_match (
    .i_entry   (tlb_rd_data),
    .i_ea_pn   (r_ea[31:12]),
    .i_pid0    (r_pid0),
    .i_pid1    (r_pid1),
    .i_pid2    (r_pid2),
    .i_is      (r_is),
    .i_pr      (r_pr),
    .o_match   (w_match),
    .o_mask    (w_mask),
    .o_exec_ok (w_exec_ok)
  );

  assign w_rpn      = tlb_rd_data[E_RPN_HI:E_RPN_LO];
  assign w_accept   = (r_state == ST_IDLE) && r_req_ready && req_valid && !flush;
  assign w_hit      = r_data_vld && w_match;
  assign w_scan_end = r_data_vld && (r_data_idx == LAST_IDX);

  // NOTE: w_next_state gets its default before the case, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_SCAN;
      ST_SCAN: if (w_hit || w_scan_end) w_next_state = ST_DONE;
      ST_DONE: if (resp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) w_next_state = ST_IDLE;
  end

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_ea        <= '0;
      r_pid0      <= '0;
      r_pid1      <= '0;
      r_pid2      <= '0;
      r_is        <= 1'b0;
      r_pr        <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_idx    <= '0;
      r_data_vld  <= 1'b0;
      r_data_idx  <= '0;
      r_resp_pa   <= '0;
      r_resp_idx  <= '0;
      r_miss      <= 1'b0;
      r_exc       <= EXC_NONE;
    end else begin
      r_state     <= w_next_state;
      r_req_ready <= (w_next_state == ST_IDLE);
      // Read data lines up with the index issued one cycle earlier.
      r_data_vld  <= (w_next_state == ST_SCAN) && r_rd_en;
      r_data_idx  <= r_rd_idx;

      if (w_accept) begin
        r_ea     <= req_ea;
        r_pid0   <= pid0;
        r_pid1   <= pid1;
        r_pid2   <= pid2;
        r_is     <= msr_is;
        r_pr     <= msr_pr;
        r_rd_en  <= 1'b1;
        r_rd_idx <= '0;
      end else if ((w_next_state == ST_SCAN) && r_rd_en && (r_rd_idx != LAST_IDX)) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end else begin
        r_rd_en  <= 1'b0;
        r_rd_idx <= '0;
      end

      if ((r_state == ST_SCAN) && (w_next_state == ST_DONE)) begin
        if (w_hit) begin
          r_resp_idx <= r_data_idx;
          r_miss     <= 1'b0;
          r_exc      <= w_exec_ok ? EXC_NONE : EXC_ISI;
          r_resp_pa  <= w_exec_ok ?
                        {(w_rpn & w_mask) | (r_ea[31:12] & ~w_mask), r_ea[11:0]} : 32'd0;
        end else begin
          r_resp_idx <= '0;
          r_miss     <= 1'b1;
          r_exc      <= EXC_ITLB_MISS;
          r_resp_pa  <= '0;
        end
      end else if (w_next_state == ST_IDLE) begin
        r_resp_idx <= '0;
        r_miss     <= 1'b0;
        r_exc      <= EXC_NONE;
        r_resp_pa  <= '0;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign tlb_rd_en  = r_rd_en;
  assign tlb_rd_idx = r_rd_idx;
  assign resp_valid = (r_state == ST_DONE);
  assign resp_pa    = r_resp_pa;
  assign resp_idx   = r_resp_idx;
  assign Miss       = r_miss;
  assign Exception  = r_exc;

endmodule

// File: tb/tb_immu_tlb_walker.sv
// Self-checking bench for immu_tlb_walker: directed scenarios plus randomized
// walks compared against a page-size based reference model of the TLB search.
module tb_immu_tlb_walker;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [31:0]      req_ea;
  logic [7:0]       pid0, pid1, pid2;
  logic             msr_is, msr_pr, flush;
  logic             tlb_rd_en;
  logic [IDX_W-1:0] tlb_rd_idx;
  logic [63:0]      tlb_rd_data;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_pa;
  logic [IDX_W-1:0] resp_idx;
  logic             Miss;
  logic [4:0]       Exception;

  immu_tlb_walker #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ea(req_ea),
    .pid0(pid0), .pid1(pid1), .pid2(pid2),
    .msr_is(msr_is), .msr_pr(msr_pr), .flush(flush),
    .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx), .tlb_rd_data(tlb_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa),
    .resp_idx(resp_idx), .Miss(Miss), .Exception(Exception)
  );

  always #5 clk = ~clk;

  // TLB array with a 1-cycle read latency.
  logic [63:0] tlb_mem [ENTRIES];
  initial tlb_rd_data = '0;
  always @(posedge clk) if (tlb_rd_en) tlb_rd_data <= tlb_mem[tlb_rd_idx];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_entry(input logic v, input logic ts, input logic [7:0] tid,
                                           input logic [19:0] epn, input logic [3:0] size,
                                           input logic [19:0] rpn, input logic [5:0] perm);
    return {v, ts, tid, epn, size, rpn, perm, 4'h0};
  endfunction

  typedef struct {
    bit          hit;
    int          idx;
    logic [31:0] pa;
    logic        miss;
    logic [4:0]  exc;
    int          lat;
    int          last_rd;
  } exp_t;

  // Reference: lowest entry whose page (4KB * 4^SIZE) contains the EA wins.
  function automatic exp_t model(input logic [31:0] ea, input logic [7:0] p0, input logic [7:0] p1,
                                 input logic [7:0] p2, input logic is, input logic pr);
    exp_t        r;
    logic [63:0] e;
    logic [7:0]  tid;
    logic [31:0] page;
    int          sz, b;
    r.hit = 0; r.idx = 0; r.pa = 0; r.miss = 1; r.exc = 5'd1;
    r.lat = ENTRIES + 1; r.last_rd = ENTRIES - 1;
    for (int i = 0; i < ENTRIES; i++) begin
      e   = tlb_mem[i];
      tid = e[61:54];
      sz  = int'(e[33:30]);
      if (sz > 7) sz = 7;
      b = 2 * sz;
      if (e[63] && (e[62] == is) && (tid == 0 || tid == p0 || tid == p1 || tid == p2) &&
          (((ea >> 12) >> b) == ({12'h000, e[53:34]} >> b))) begin
        r.hit = 1; r.idx = i;
        break;
      end
    end
    if (r.hit) begin
      e    = tlb_mem[r.idx];
      sz   = int'(e[33:30]);
      if (sz > 7) sz = 7;
      page = 32'h1000 << (2 * sz);
      r.miss    = 0;
      r.lat     = r.idx + 2;
      r.last_rd = (r.idx + 1 > ENTRIES - 1) ? ENTRIES - 1 : r.idx + 1;
      if (pr ? e[9] : e[6]) begin
        r.exc = 5'd0;
        r.pa  = ({e[29:10], 12'h000} & ~(page - 1)) | (ea & (page - 1));
      end else begin
        r.exc = 5'd2;
        r.pa  = 32'd0;
      end
    end
    return r;
  endfunction

  task automatic clear_tlb();
    for (int i = 0; i < ENTRIES; i++) tlb_mem[i] = '0;
  endtask

  task automatic run_walk(input string tag, input logic [31:0] ea, input logic [7:0] p0,
                          input logic [7:0] p1, input logic [7:0] p2, input logic is,
                          input logic pr, input int hold);
    exp_t x;
    int   cyc, last, nrd;
    x = model(ea, p0, p1, p2, is, pr);
    cyc = 0;
    while (!req_ready && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_ea = ea; pid0 = p0; pid1 = p1; pid2 = p2; msr_is = is; msr_pr = pr;
    req_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble request inputs: the walk must use the latched copies.
    req_valid = 1'b0; req_ea = $urandom; pid0 = 8'($urandom); pid1 = 8'($urandom);
    pid2 = 8'($urandom); msr_is = ~is; msr_pr = ~pr;
    cyc = 0; last = -1; nrd = 0;
    while (!resp_valid && cyc < 200) begin
      if (tlb_rd_en) begin last = int'(tlb_rd_idx); nrd++; end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(x.lat));
    check({tag, " last_rd_idx"}, 32'(last), 32'(x.last_rd));
    check({tag, " read_count"}, 32'(nrd), 32'(x.last_rd + 1));
    for (int h = 0; h <= hold; h++) begin
      check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " resp_pa"}, resp_pa, x.pa);
      check({tag, " Miss"}, 32'(Miss), 32'(x.miss));
      check({tag, " Exception"}, 32'(Exception), 32'(x.exc));
      if (x.hit) check({tag, " resp_idx"}, 32'(resp_idx), 32'(x.idx));
      if (h < hold) begin @(posedge clk); #1; end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({tag, " resp_drop"}, 32'(resp_valid), 32'd0);
    check({tag, " req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic start_walk(input logic [31:0] ea);
    req_ea = ea; pid0 = 8'h00; pid1 = 8'h00; pid2 = 8'h00; msr_is = 1'b0; msr_pr = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ea;
    logic [7:0]  p0, p1, p2, tid;
    logic        is, pr;
    int          vis;

    rst = 1'b0; req_valid = 1'b0; req_ea = '0; pid0 = '0; pid1 = '0; pid2 = '0;
    msr_is = 1'b0; msr_pr = 1'b0; flush = 1'b0; resp_ready = 1'b0;
    clear_tlb();
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst tlb_rd_en", 32'(tlb_rd_en), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_pa", resp_pa, 32'd0);
    check("rst Miss", 32'(Miss), 32'd0);
    check("rst Exception", 32'(Exception), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst req_ready", 32'(req_ready), 32'd1);

    // Single hit at entry 5, supervisor execute allowed.
    tlb_mem[5] = mk_entry(1'b1, 1'b0, 8'h12, 20'h40000, 4'd0, 20'h80000, 6'b000100);
    run_walk("hit5", 32'h40000ABC, 8'h00, 8'h12, 8'h00, 1'b0, 1'b0, 0);
    run_walk("isi5", 32'h40000ABC, 8'h00, 8'h12, 8'h00, 1'b0, 1'b1, 0);

    // Two global matches: lowest index wins.
    clear_tlb();
    tlb_mem[3] = mk_entry(1'b1, 1'b0, 8'h00, 20'h40000, 4'd0, 20'h11111, 6'b100100);
    tlb_mem[9] = mk_entry(1'b1, 1'b0, 8'h00, 20'h40000, 4'd0, 20'h22222, 6'b100100);
    run_walk("dual", 32'h40000123, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0);

    clear_tlb();
    run_walk("miss", 32'hDEADB000, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1);

    // 64KB page, response held for 4 cycles.
    tlb_mem[20] = mk_entry(1'b1, 1'b0, 8'h00, 20'h12340, 4'd2, 20'h55550, 6'b000100);
    run_walk("size2", 32'h1234F00C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 4);

    // Flush in the middle of a walk.
    clear_tlb();
    tlb_mem[40] = mk_entry(1'b1, 1'b0, 8'h00, 20'h00001, 4'd0, 20'h00002, 6'b000100);
    start_walk(32'h00001000);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush tlb_rd_en", 32'(tlb_rd_en), 32'd0);
    check("flush resp_valid", 32'(resp_valid), 32'd0);
    check("flush req_ready", 32'(req_ready), 32'd1);
    vis = 0;
    for (int i = 0; i < 60; i++) begin @(posedge clk); #1; if (resp_valid) vis++; end
    check("flush no_resp", 32'(vis), 32'd0);

    // Flush coincident with a request in IDLE: not accepted.
    req_ea = 32'h00001000; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req tlb_rd_en", 32'(tlb_rd_en), 32'd0);
    check("flush_req req_ready", 32'(req_ready), 32'd1);

    // Reset mid-walk clears outputs without waiting for a clock.
    start_walk(32'h00001000);
    repeat (3) begin @(posedge clk); #1; end
    check("midrst walking", 32'(tlb_rd_en), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst tlb_rd_en", 32'(tlb_rd_en), 32'd0);
    check("midrst tlb_rd_idx", 32'(tlb_rd_idx), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd0);
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst recover", 32'(req_ready), 32'd1);

    // Randomized walks against the reference model.
    for (int n = 0; n < 25; n++) begin
      ea = $urandom; p0 = 8'($urandom); p1 = 8'($urandom); p2 = 8'($urandom);
      is = 1'($urandom); pr = 1'($urandom);
      for (int i = 0; i < ENTRIES; i++) begin
        if ($urandom_range(0, 9) < 7) begin
          tlb_mem[i] = {$urandom, $urandom};
        end else begin
          case ($urandom_range(0, 3))
            0:       tid = 8'h00;
            1:       tid = p0;
            2:       tid = p2;
            default: tid = 8'($urandom);
          endcase
          tlb_mem[i] = mk_entry(1'b1, ($urandom_range(0, 3) == 0) ? ~is : is, tid,
                                ea[31:12] ^ 20'($urandom_range(0, 255)), 4'($urandom),
                                20'($urandom), 6'($urandom));
        end
      end
      run_walk($sformatf("rnd%0d", n), ea, p0, p1, p2, is, pr, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
